mc_decoder: RTL and testbench

- Multicycle control decoder that sits directly upstream of the conditional-execution logic.
- Holds the main control FSM that sequences each ARM instruction through fetch, decode, execute, memory and writeback states, plus a combinational ALU sub-decoder.
- Drives the datapath multiplexer selects, IRWrite and NextPC.
- Drives the unconditioned PCS, RegW, MemW, Branch and FlagW strobes; the downstream conditional logic gates these with the condition check.

---
 rtl/mc_decoder.sv | 172 +++++++++++++++++
 tb/tb_mc_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_decoder.sv
// mc_decoder -- multicycle ARM control decoder.
//
// Main control FSM plus a combinational ALU sub-decoder. Drives the datapath
// mux selects, IRWrite and NextPC, and the unconditioned PCS/RegW/MemW/Branch/
// FlagW strobes that the downstream condition logic gates.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   Op          Instr[27:26] instruction class
//   Funct       Instr[25:20] {I, cmd[3:0], S/L}
//   Rd          Instr[15:12] destination register
//   IRWrite     instruction register load enable
//   NextPC      unconditional PC write (fetch increment)
//   AdrSrc      memory address select: 0 = PC, 1 = ALUOut
//   ALUSrcA     0 = RD1, 1 = PC
//   ALUSrcB     00 = RD2/shifted, 01 = ExtImm, 10 = constant 4
//   ResultSrc   00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUControl  00 ADD, 01 SUB, 10 AND, 11 ORR
//   FlagW       [1] NZ write request, [0] CV write request
//   PCS         PC-source request
//   RegW        register write request
//   MemW        memory write request
//   Branch      branch request
//   State       current FSM state
//
// state  | meaning
// FETCH  | load IR, PC <= PC+4
// DECODE | read registers, PC+8 onto the result bus
// MEMADR | compute load/store address
// MEMRD  | read data memory
// MEMWB  | write loaded data to Rd
// MEMWR  | write data memory
// EXECR  | data-processing, register operand
// EXECI  | data-processing, immediate operand
// ALUWB  | write ALU result to Rd
// BRANCH | compute branch target, request PC load

module mc_decoder #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUControl,
    output logic [1:0]         FlagW,
    output logic               PCS,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 0,
        DECODE = 1,
        MEMADR = 2,
        MEMRD  = 3,
        MEMWB  = 4,
        MEMWR  = 5,
        EXECR  = 6,
        EXECI  = 7,
        ALUWB  = 8,
        BRANCH = 9
    } state_t;

    state_t state;
    state_t state_next;
    logic   alu_op;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        RegW       = 1'b0;
        MemW       = 1'b0;
        Branch     = 1'b0;
        alu_op     = 1'b0;
        case (state)
            FETCH: begin
                state_next = DECODE;
                IRWrite    = 1'b1;
                NextPC     = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
            end
            DECODE: begin
                case (Op)
                    2'b00:   state_next = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                state_next = Funct[0] ? MEMRD : MEMWR;
                ALUSrcB    = 2'b01;
            end
            MEMRD: begin
                state_next = MEMWB;
                AdrSrc     = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECR: begin
                state_next = ALUWB;
                alu_op     = 1'b1;
            end
            EXECI: begin
                state_next = ALUWB;
                ALUSrcB    = 2'b01;
                alu_op     = 1'b1;
            end
            ALUWB: begin
                RegW = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // Unrecognised commands leave both ALUControl and FlagW at zero, so an
    // unsupported opcode cannot corrupt the flags.
    always_comb begin
        ALUControl = 2'b00;
        FlagW      = 2'b00;
        if (alu_op) begin
            case (Funct[4:1])
                4'b0100: begin ALUControl = 2'b00; FlagW = {Funct[0], Funct[0]}; end
                4'b0010: begin ALUControl = 2'b01; FlagW = {Funct[0], Funct[0]}; end
                4'b0000: begin ALUControl = 2'b10; FlagW = {Funct[0], 1'b0};     end
                4'b1100: begin ALUControl = 2'b11; FlagW = {Funct[0], 1'b0};     end
                default: begin ALUControl = 2'b00; FlagW = 2'b00;                end
            endcase
        end
    end

    assign PCS   = Branch | (RegW & (Rd == 4'b1111));
    assign State = state;

endmodule

// File: tb/tb_mc_decoder.sv
// tb_mc_decoder -- directed bench for mc_decoder.
// Outputs are packed into one control word {IRWrite, NextPC, AdrSrc, ALUSrcA,
// ALUSrcB, ResultSrc, ALUControl, FlagW, PCS, RegW, MemW, Branch} and compared
// against hand-computed words at each negative clock edge.

module tb_mc_decoder;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
    logic       PCS, RegW, MemW, Branch;
    logic [3:0] State;
    logic [15:0] ctl;

    int passed = 0;
    int total  = 0;

    mc_decoder #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .Branch(Branch),
        .State(State)
    );

    assign ctl = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                  ALUControl, FlagW, PCS, RegW, MemW, Branch};

    always #5 clk = ~clk;

    localparam logic [15:0] C_FETCH  = 16'hDA00;
    localparam logic [15:0] C_DECODE = 16'h1A00;

    localparam logic [3:0]  LDR_ST  [6] = '{0, 1, 2, 3, 4, 0};
    localparam logic [15:0] LDR_CTL [6] = '{16'hDA00, 16'h1A00, 16'h0400, 16'h2000, 16'h0104, 16'hDA00};
    localparam logic [3:0]  STR_ST  [5] = '{0, 1, 2, 5, 0};
    localparam logic [15:0] STR_CTL [5] = '{16'hDA00, 16'h1A00, 16'h0400, 16'h2002, 16'hDA00};
    localparam logic [3:0]  B_ST    [4] = '{0, 1, 9, 0};
    localparam logic [15:0] B_CTL   [4] = '{16'hDA00, 16'h1A00, 16'h0609, 16'hDA00};
    localparam logic [3:0]  UND_ST  [3] = '{0, 1, 0};
    localparam logic [15:0] UND_CTL [3] = '{16'hDA00, 16'h1A00, 16'hDA00};

    // ADDS R15, ORR imm, SUBS, ANDS, MOVS (unsupported cmd)
    localparam logic [5:0]  DP_FUNCT [5] = '{6'b001001, 6'b111000, 6'b000101, 6'b000001, 6'b011011};
    localparam logic [3:0]  DP_RD    [5] = '{4'd15, 4'd2, 4'd1, 4'd0, 4'd4};
    localparam logic [3:0]  DP_XST   [5] = '{4'd6, 4'd7, 4'd6, 4'd6, 4'd6};
    localparam logic [15:0] DP_XCTL  [5] = '{16'h0030, 16'h04C0, 16'h0070, 16'h00A0, 16'h0000};
    localparam logic [15:0] DP_WCTL  [5] = '{16'h000C, 16'h0004, 16'h0004, 16'h0004, 16'h0004};

    // LDR R15 followed immediately by B
    localparam logic [3:0]  BB_ST  [9] = '{0, 1, 2, 3, 4, 0, 1, 9, 0};
    localparam logic [15:0] BB_CTL [9] = '{16'hDA00, 16'h1A00, 16'h0400, 16'h2000, 16'h010C,
                                           16'hDA00, 16'h1A00, 16'h0609, 16'hDA00};

    task automatic test_reset();
        Op = 2'b00; Funct = 6'b001000; Rd = 4'd1;
        @(negedge clk);
        total++;
        if (State !== 4'd0 || ctl !== C_FETCH)
            $display("FAIL reset_hold: state=%0d ctl=%h required state=0 ctl=%h", State, ctl, C_FETCH);
        else passed++;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (State !== LDR_ST[0] + 4'(i == 1) + 4'(i == 2) * 4'd6)
                $display("FAIL reset_run[%0d]: state=%0d", i, State);
            else passed++;
        end
        // now in EXECR; abandon the instruction
        reset = 1'b0;
        #1;
        total++;
        if (State !== 4'd0)
            $display("FAIL reset_async: state=%0d required 0", State);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (State !== 4'd0)
                $display("FAIL reset_held[%0d]: state=%0d required 0", i, State);
            else passed++;
        end
        Op = 2'b11;
        reset = 1'b1;
        total++;
        if (State !== 4'd0 || IRWrite !== 1'b1 || NextPC !== 1'b1)
            $display("FAIL reset_release: state=%0d IRWrite=%b NextPC=%b required 0 1 1", State, IRWrite, NextPC);
        else passed++;
        @(negedge clk);
        total++;
        if (State !== 4'd1 || ctl !== C_DECODE)
            $display("FAIL reset_decode: state=%0d ctl=%h required 1 %h", State, ctl, C_DECODE);
        else passed++;
        @(negedge clk);
        total++;
        if (State !== 4'd0)
            $display("FAIL reset_return: state=%0d required 0", State);
        else passed++;
    endtask

    task automatic test_ldr();
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd3;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (State !== LDR_ST[i] || ctl !== LDR_CTL[i])
                $display("FAIL ldr[%0d]: state=%0d ctl=%h required %0d %h", i, State, ctl, LDR_ST[i], LDR_CTL[i]);
            else passed++;
        end
    endtask

    task automatic test_str();
        Op = 2'b01; Funct = 6'b011000; Rd = 4'd5;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (State !== STR_ST[i] || ctl !== STR_CTL[i])
                $display("FAIL str[%0d]: state=%0d ctl=%h required %0d %h", i, State, ctl, STR_ST[i], STR_CTL[i]);
            else passed++;
        end
    endtask

    task automatic test_data_processing();
        logic [3:0]  exp_st  [5];
        logic [15:0] exp_ctl [5];
        for (int n = 0; n < 5; n++) begin
            Op = 2'b00; Funct = DP_FUNCT[n]; Rd = DP_RD[n];
            exp_st  = '{4'd0, 4'd1, DP_XST[n], 4'd8, 4'd0};
            exp_ctl = '{C_FETCH, C_DECODE, DP_XCTL[n], DP_WCTL[n], C_FETCH};
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(negedge clk);
                total++;
                if (State !== exp_st[i] || ctl !== exp_ctl[i])
                    $display("FAIL dp%0d[%0d]: state=%0d ctl=%h required %0d %h",
                             n, i, State, ctl, exp_st[i], exp_ctl[i]);
                else passed++;
            end
        end
    endtask

    task automatic test_branch();
        Op = 2'b10; Funct = 6'b000000; Rd = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (State !== B_ST[i] || ctl !== B_CTL[i])
                $display("FAIL branch[%0d]: state=%0d ctl=%h required %0d %h", i, State, ctl, B_ST[i], B_CTL[i]);
            else passed++;
        end
    endtask

    task automatic test_undefined();
        Op = 2'b11; Funct = 6'b111111; Rd = 4'd15;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (State !== UND_ST[i] || ctl !== UND_CTL[i])
                $display("FAIL undef[%0d]: state=%0d ctl=%h required %0d %h", i, State, ctl, UND_ST[i], UND_CTL[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        Op = 2'b01; Funct = 6'b011001; Rd = 4'd15;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 5) begin Op = 2'b10; Funct = 6'b000000; Rd = 4'd0; end
            total++;
            if (State !== BB_ST[i] || ctl !== BB_CTL[i])
                $display("FAIL b2b[%0d]: state=%0d ctl=%h required %0d %h", i, State, ctl, BB_ST[i], BB_CTL[i]);
            else passed++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clk   = 1'b0;
        reset = 1'b0;
        Op    = 2'b00;
        Funct = 6'b000000;
        Rd    = 4'd0;
        test_reset();
        test_ldr();
        test_str();
        test_data_processing();
        test_branch();
        test_undefined();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
